maze_grid_responder: RTL and testbench

MAZE_GRID_RESPONDER -- requirements
Module: maze_grid_responder

---
 rtl/maze_grid_responder.sv | 132 +++++++++++++
 tb/tb_maze_grid_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_grid_responder.sv
// Maze wall-query responder: a 16x16 one-bit wall map shared by a horizontal and a
// vertical intersection finder, with round-robin arbitration and one-cycle query latency.
module maze_grid_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic        h_req,
    input  logic [11:0] h_x,
    input  logic [11:0] h_y,
    output logic        h_ack,
    output logic        h_wall,
    output logic        h_oob,
    input  logic        v_req,
    input  logic [11:0] v_x,
    input  logic [11:0] v_y,
    output logic        v_ack,
    output logic        v_wall,
    output logic        v_oob,
    input  logic        wr_en,
    input  logic [3:0]  wr_cell_x,
    input  logic [3:0]  wr_cell_y,
    input  logic        wr_wall,
    input  logic        map_clear
);

    localparam int GRID = 16;

    // Boot pattern: a solid border, open interior. Bit index within a row is the column.
    function automatic logic [GRID-1:0] boot_row(input logic [3:0] row);
        if (row == 4'd0 || row == 4'd15) begin
            return {GRID{1'b1}};
        end
        return 16'h8001;
    endfunction

    logic [GRID-1:0] map_rows [GRID];

    for (genvar gi = 0; gi < GRID; gi++) begin : g_row
        logic [GRID-1:0] row_q;
        logic [GRID-1:0] row_d;

        // Clear wins over a simultaneous write, so that write is simply lost.
        always_comb begin
            row_d = row_q;
            if (map_clear) begin
                row_d = boot_row(4'(gi));
            end else if (wr_en && (wr_cell_y == 4'(gi))) begin
                row_d[wr_cell_x] = wr_wall;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                row_q <= boot_row(4'(gi));
            end else begin
                row_q <= row_d;
            end
        end

        assign map_rows[gi] = row_q;
    end

    logic h_ack_q,  h_ack_d;
    logic h_wall_q, h_wall_d;
    logic h_oob_q,  h_oob_d;
    logic v_ack_q,  v_ack_d;
    logic v_wall_q, v_wall_d;
    logic v_oob_q,  v_oob_d;
    logic prio_h_q, prio_h_d;

    logic h_elig, v_elig, h_grant, v_grant;
    logic h_pt_oob, v_pt_oob, h_cell, v_cell;

    // Only the upper coordinate bits select a cell; the in-cell offset is irrelevant here.
    logic unused_offsets;
    assign unused_offsets = ^{h_x[5:0], h_y[5:0], v_x[5:0], v_y[5:0]};

    always_comb begin
        // A port in its ack cycle is still showing the request just served.
        h_elig  = h_req & ~h_ack_q;
        v_elig  = v_req & ~v_ack_q;
        h_grant = h_elig & (~v_elig | prio_h_q);
        v_grant = v_elig & ~h_grant;

        // Anything at or beyond 1024 (including negative values) lies outside the maze.
        h_pt_oob = |{h_x[11:10], h_y[11:10]};
        v_pt_oob = |{v_x[11:10], v_y[11:10]};
        h_cell   = map_rows[h_y[9:6]][h_x[9:6]];
        v_cell   = map_rows[v_y[9:6]][v_x[9:6]];

        h_ack_d  = h_grant;
        h_wall_d = h_grant ? (h_cell & ~h_pt_oob) : h_wall_q;
        h_oob_d  = h_grant ? h_pt_oob : h_oob_q;
        v_ack_d  = v_grant;
        v_wall_d = v_grant ? (v_cell & ~v_pt_oob) : v_wall_q;
        v_oob_d  = v_grant ? v_pt_oob : v_oob_q;

        prio_h_d = prio_h_q;
        if (h_grant) begin
            prio_h_d = 1'b0;
        end else if (v_grant) begin
            prio_h_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_ack_q  <= 1'b0;
            h_wall_q <= 1'b0;
            h_oob_q  <= 1'b0;
            v_ack_q  <= 1'b0;
            v_wall_q <= 1'b0;
            v_oob_q  <= 1'b0;
            prio_h_q <= 1'b1;
        end else begin
            h_ack_q  <= h_ack_d;
            h_wall_q <= h_wall_d;
            h_oob_q  <= h_oob_d;
            v_ack_q  <= v_ack_d;
            v_wall_q <= v_wall_d;
            v_oob_q  <= v_oob_d;
            prio_h_q <= prio_h_d;
        end
    end

    assign h_ack  = h_ack_q;
    assign h_wall = h_wall_q;
    assign h_oob  = h_oob_q;
    assign v_ack  = v_ack_q;
    assign v_wall = v_wall_q;
    assign v_oob  = v_oob_q;

endmodule

// File: tb/tb_maze_grid_responder.sv
// Bench for maze_grid_responder: directed scenarios followed by random traffic, all
// compared cycle by cycle against a rule-level reference model.
module tb_maze_grid_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        h_req, v_req, wr_en, wr_wall, map_clear;
    logic [11:0] h_x, h_y, v_x, v_y;
    logic [3:0]  wr_cell_x, wr_cell_y;
    logic        h_ack, h_wall, h_oob, v_ack, v_wall, v_oob;

    maze_grid_responder dut (
        .clock(clock), .reset(reset),
        .h_req(h_req), .h_x(h_x), .h_y(h_y), .h_ack(h_ack), .h_wall(h_wall), .h_oob(h_oob),
        .v_req(v_req), .v_x(v_x), .v_y(v_y), .v_ack(v_ack), .v_wall(v_wall), .v_oob(v_oob),
        .wr_en(wr_en), .wr_cell_x(wr_cell_x), .wr_cell_y(wr_cell_y), .wr_wall(wr_wall),
        .map_clear(map_clear)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: map as [row][col], expected outputs, and who wins the next tie.
    bit mmap [16][16];
    bit e_h_ack, e_h_wall, e_h_oob, e_v_ack, e_v_wall, e_v_oob;
    bit h_wins_tie;

    task automatic model_boot();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mmap[r][c] = (r == 0 || r == 15 || c == 0 || c == 15);
    endtask

    function automatic bit point_oob(input logic [11:0] x, input logic [11:0] y);
        return (int'(x) >= 1024) || (int'(y) >= 1024);
    endfunction

    function automatic bit point_wall(input logic [11:0] x, input logic [11:0] y);
        if (point_oob(x, y)) return 1'b0;
        return mmap[int'(y) / 64][int'(x) / 64];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock: predict from the inputs of this cycle, then compare after the edge.
    task automatic step();
        bit he, ve, gh, gv;
        bit n_h_ack, n_h_wall, n_h_oob, n_v_ack, n_v_wall, n_v_oob;
        n_h_wall = e_h_wall; n_h_oob = e_h_oob;
        n_v_wall = e_v_wall; n_v_oob = e_v_oob;
        if (reset) begin
            n_h_ack = 0; n_h_wall = 0; n_h_oob = 0;
            n_v_ack = 0; n_v_wall = 0; n_v_oob = 0;
            h_wins_tie = 1;
            model_boot();
        end else begin
            he = h_req && !e_h_ack;
            ve = v_req && !e_v_ack;
            gh = he && (!ve || h_wins_tie);
            gv = ve && !gh;
            n_h_ack = gh;
            n_v_ack = gv;
            if (gh) begin
                n_h_wall = point_wall(h_x, h_y);
                n_h_oob  = point_oob(h_x, h_y);
                h_wins_tie = 0;
            end
            if (gv) begin
                n_v_wall = point_wall(v_x, v_y);
                n_v_oob  = point_oob(v_x, v_y);
                h_wins_tie = 1;
            end
            if (map_clear) model_boot();
            else if (wr_en) mmap[wr_cell_y][wr_cell_x] = wr_wall;
        end
        @(posedge clock);
        #1;
        cyc++;
        e_h_ack = n_h_ack; e_h_wall = n_h_wall; e_h_oob = n_h_oob;
        e_v_ack = n_v_ack; e_v_wall = n_v_wall; e_v_oob = n_v_oob;
        check("h_ack", h_ack, e_h_ack);
        check("h_wall", h_wall, e_h_wall);
        check("h_oob", h_oob, e_h_oob);
        check("v_ack", v_ack, e_v_ack);
        check("v_wall", v_wall, e_v_wall);
        check("v_oob", v_oob, e_v_oob);
        check("ack_exclusive", h_ack & v_ack, 1'b0);
    endtask

    function automatic logic [11:0] rand_coord();
        if ($urandom_range(0, 7) == 0) return 12'($urandom_range(0, 4095));
        return 12'($urandom_range(0, 1023));
    endfunction

    initial begin
        reset = 1; h_req = 0; v_req = 0; wr_en = 0; wr_wall = 0; map_clear = 0;
        h_x = 0; h_y = 0; v_x = 0; v_y = 0; wr_cell_x = 0; wr_cell_y = 0;
        e_h_ack = 0; e_h_wall = 0; e_h_oob = 0; e_v_ack = 0; e_v_wall = 0; e_v_oob = 0;
        h_wins_tie = 1;
        model_boot();
        step(); step();
        reset = 0;

        // Open interior cell, then a border cell.
        h_req = 1; h_x = 100; h_y = 100;
        step();
        check("q100_ack", h_ack, 1'b1);
        check("q100_wall", h_wall, 1'b0);
        h_x = 10; h_y = 500;
        step();
        check("q10_ackcycle_no_regrant", h_ack, 1'b0);
        step();
        check("q10_ack", h_ack, 1'b1);
        check("q10_wall", h_wall, 1'b1);
        h_req = 0;

        // A write is visible to a query in the following cycle.
        wr_en = 1; wr_cell_x = 3; wr_cell_y = 2; wr_wall = 1;
        step();
        wr_en = 0; v_req = 1; v_x = 200; v_y = 130;
        step();
        check("wr_v_ack", v_ack, 1'b1);
        check("wr_v_wall", v_wall, 1'b1);
        check("wr_v_oob", v_oob, 1'b0);
        v_req = 0;
        step();

        // Both held: acks alternate, horizontal first.
        h_req = 1; h_x = 300; h_y = 300; v_req = 1; v_x = 700; v_y = 900;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_h", h_ack, (i % 2) == 0);
            check("rr_v", v_ack, (i % 2) == 1);
        end
        h_req = 0; v_req = 0;
        step();

        // Out of bounds points.
        h_req = 1; h_x = 1024; h_y = 5;
        step();
        check("oob1024_oob", h_oob, 1'b1);
        check("oob1024_wall", h_wall, 1'b0);
        h_req = 0; v_req = 1; v_x = 12'hFFF; v_y = 40;
        step();
        check("oobneg_oob", v_oob, 1'b1);
        check("oobneg_wall", v_wall, 1'b0);
        v_req = 0;
        step();

        // Same-cycle write and query of one cell: query sees the old value.
        wr_en = 1; wr_cell_x = 4; wr_cell_y = 4; wr_wall = 1;
        h_req = 1; h_x = 260; h_y = 260;
        step();
        check("nobypass_old", h_wall, 1'b0);
        wr_en = 0; h_req = 0;
        step();
        h_req = 1;
        step();
        check("nobypass_new", h_wall, 1'b1);
        h_req = 0;
        step();

        // Clear beats a simultaneous write; a query in the clear cycle sees pre-clear data.
        wr_en = 1; wr_cell_x = 5; wr_cell_y = 5; wr_wall = 1; map_clear = 1;
        h_req = 1; h_x = 200; h_y = 130;
        step();
        check("clr_preclear", h_wall, 1'b1);
        wr_en = 0; map_clear = 0; h_req = 0;
        step();
        h_req = 1; h_x = 330; h_y = 330;
        step();
        check("clr_write_lost", h_wall, 1'b0);
        h_req = 0; v_req = 1; v_x = 200; v_y = 130;
        step();
        check("clr_cell_restored", v_wall, 1'b0);
        v_req = 0;
        step();

        // Give both ports nonzero results, then reset during a grant cycle.
        h_req = 1; h_x = 10; h_y = 500; v_req = 1; v_x = 1000; v_y = 1000;
        step(); step();
        h_req = 0; v_req = 0;
        step();
        h_req = 1; h_x = 10; h_y = 10; reset = 1;
        step();
        check("rst_no_ack", h_ack, 1'b0);
        check("rst_h_wall", h_wall, 1'b0);
        check("rst_v_wall", v_wall, 1'b0);
        reset = 0;
        step();
        check("rst_req_served", h_ack, 1'b1);
        check("rst_req_wall", h_wall, 1'b1);
        h_req = 0;
        step();

        // Random traffic; requests are held until acknowledged.
        for (int i = 0; i < 400; i++) begin
            if (!h_req || e_h_ack) begin
                h_req = 1'($urandom_range(0, 1));
                h_x = rand_coord(); h_y = rand_coord();
            end
            if (!v_req || e_v_ack) begin
                v_req = 1'($urandom_range(0, 1));
                v_x = rand_coord(); v_y = rand_coord();
            end
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_cell_x = 4'($urandom_range(0, 15));
            wr_cell_y = 4'($urandom_range(0, 15));
            wr_wall   = 1'($urandom_range(0, 1));
            map_clear = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 0; h_req = 0; v_req = 0; wr_en = 0; map_clear = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
